// File: rtl/alu_control_seq.sv
// ALU control decode plus a multi-cycle mult/div sequencer with hazard stall for the EX stage.
// Define ALUCTRL_EXT_OPS_EN to decode nor/xor/sltu/srl/sll as real ALU operations.
`timescale 1ns/1ps

module alu_control_seq #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 6
) (
   input  logic       Clk,
   input  logic       RstN,
   input  logic       Valid,
   input  logic       Flush,
   input  logic [1:0] UCon,
   input  logic [5:0] InData,
   output logic [3:0] ALUSelect,
   output logic       MdStart,
   output logic [1:0] MdOp,
   output logic       MdBusy,
   output logic       HiLoWe,
   output logic       Stall,
   output logic       IllegalOp
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_nextCnt;
   logic             r_mdStart;
   logic             r_illegal;
   logic [1:0]       r_mdOp;
   logic             w_undef;
   logic             w_isRType;
   logic             w_isMd;
   logic             w_isMf;
   logic             w_accept;

   // Undefined R-type functs select add so the ALU stays harmless while the trap is raised.
   always_comb begin
      ALUSelect = 4'b0010;
      w_undef   = 1'b0;
      case (UCon)
         2'b00: ALUSelect = 4'b0010;
         2'b01: ALUSelect = 4'b0110;
         2'b11: ALUSelect = 4'b0001;
         default: begin
            case (InData)
               6'b100000: ALUSelect = 4'b0010;
               6'b100010: ALUSelect = 4'b0110;
               6'b100100: ALUSelect = 4'b0000;
               6'b100101: ALUSelect = 4'b0001;
               6'b101010: ALUSelect = 4'b0111;
`ifdef ALUCTRL_EXT_OPS_EN
               6'b100111: ALUSelect = 4'b1100;
               6'b100110: ALUSelect = 4'b0011;
               6'b101011: ALUSelect = 4'b1000;
               6'b000010: ALUSelect = 4'b1010;
               6'b000000: ALUSelect = 4'b1001;
`else
               6'b000000: ALUSelect = 4'b0010;
`endif
               6'b010000, 6'b010010,
               6'b011000, 6'b011001,
               6'b011010, 6'b011011: ALUSelect = 4'b0010;
               default: begin
                  ALUSelect = 4'b0010;
                  w_undef   = 1'b1;
               end
            endcase
         end
      endcase
   end

   assign w_isRType = (UCon == 2'b10);
   assign w_isMd    = w_isRType && (InData[5:2] == 4'b0110);
   assign w_isMf    = w_isRType && ((InData == 6'b010000) || (InData == 6'b010010));

   assign MdBusy    = (r_state != IDLE);
   assign Stall     = RstN && Valid && MdBusy && (w_isMd || w_isMf);
   assign w_accept  = RstN && Valid && w_isMd && !Flush && !Stall && (r_state == IDLE);
   assign HiLoWe    = RstN && (r_state == DONE) && !Flush;
   assign MdStart   = r_mdStart;
   assign MdOp      = r_mdOp;
   assign IllegalOp = r_illegal;

   // Flush wins over counter expiry so an aborted op can never reach DONE.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = BUSY;
               w_nextCnt   = InData[1] ? DIV_CNT : MUL_CNT;
            end
         end
         BUSY: begin
            if (Flush) begin
               w_nextState = IDLE;
            end else if (r_cnt == '0) begin
               w_nextState = DONE;
            end else begin
               w_nextCnt = r_cnt - 1'b1;
            end
         end
         DONE: w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!RstN) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_mdStart <= 1'b0;
         r_illegal <= 1'b0;
         r_mdOp    <= 2'b00;
      end else begin
         r_state   <= w_nextState;
         r_cnt     <= w_nextCnt;
         r_mdStart <= w_accept;
         r_illegal <= Valid && !Flush && w_undef;
         if (w_accept) begin
            r_mdOp <= InData[1:0];
         end
      end
   end

endmodule
